// File: rtl/multi_mode_ff_bank.sv
// rtl/multi_mode_ff_bank.sv - WIDTH-bit SR/JK/D/T flip-flop bank with SR violation tracking
//
// Purpose:
//   A bank of WIDTH flip-flops. All bits share one run-time mode (SR, JK, D or T).
//   Each SR 1/1 input pair is treated as a violation. A violation is reported one
//   cycle later on illegal/illegal_mask. It is also counted in a saturating counter
//   and recorded in a sticky flag.
//
// Ports:
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   en           update enable (0 = bank holds, no violation detection)
//   mode         00 SR, 01 JK, 10 D, 11 T
//   a            per-bit S / J / D / T input
//   b            per-bit R / K input (ignored in D and T modes)
//   clr_err      synchronous clear of err_cnt and err_sticky
//   q, qn        registered state and its complement
//   illegal      one-cycle pulse after an SR violation cycle
//   illegal_mask per-bit violation bits for that cycle
//   err_cnt      saturating count of violation cycles
//   err_sticky   set on any violation, held until clr_err

module multi_mode_ff_bank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RST_VAL   = '0,
    parameter int                 ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  clr_err,
    output logic [WIDTH-1:0]      q,
    output logic [WIDTH-1:0]      qn,
    output logic                  illegal,
    output logic [WIDTH-1:0]      illegal_mask,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  err_sticky
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic [WIDTH-1:0]     r_q;
    logic                 r_illegal;
    logic [WIDTH-1:0]     r_illegal_mask;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 r_err_sticky;

    logic [WIDTH-1:0]     w_next_q;
    logic [WIDTH-1:0]     w_viol_mask;
    logic                 w_viol;

    always_comb begin
        w_next_q    = r_q;
        w_viol_mask = '0;
        if (en) begin
            case (mode)
                // Set wins only when R is low and reset wins only when S is low.
                // A 1/1 pair therefore falls through to hold, as required.
                MODE_SR: begin
                    w_next_q    = (a & ~b) | (r_q & ~(~a & b));
                    w_viol_mask = a & b;
                end
                MODE_JK: w_next_q = (a & ~r_q) | (~b & r_q);
                MODE_D:  w_next_q = a;
                MODE_T:  w_next_q = r_q ^ a;
                default: w_next_q = r_q;
            endcase
        end
    end

    assign w_viol = |w_viol_mask;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_q            <= RST_VAL;
            r_illegal      <= 1'b0;
            r_illegal_mask <= '0;
            r_err_cnt      <= '0;
            r_err_sticky   <= 1'b0;
        end else begin
            r_q            <= w_next_q;
            r_illegal      <= w_viol;
            r_illegal_mask <= w_viol_mask;
            // Clearing takes priority, so a violation on the clearing edge is
            // still reported on illegal but leaves no trace in the counters.
            if (clr_err) begin
                r_err_cnt    <= '0;
                r_err_sticky <= 1'b0;
            end else if (w_viol) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != CNT_MAX) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign q            = r_q;
    assign qn           = ~r_q;
    assign illegal      = r_illegal;
    assign illegal_mask = r_illegal_mask;
    assign err_cnt      = r_err_cnt;
    assign err_sticky   = r_err_sticky;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb/tb_multi_mode_ff_bank.sv - self-checking bench for multi_mode_ff_bank

module tb_multi_mode_ff_bank;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       clr_err;

    logic [7:0] q, qn, illegal_mask;
    logic       illegal, err_sticky;
    logic [7:0] err_cnt;

    logic [7:0] q2, qn2, illegal_mask2;
    logic       illegal2, err_sticky2;
    logic [1:0] err_cnt2;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state.
    logic [7:0] m_q;
    logic       m_ill;
    logic [7:0] m_mask;
    int         m_cnt8;
    int         m_cnt2;
    logic       m_sticky;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .n_rst(n_rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q), .qn(qn), .illegal(illegal),
        .illegal_mask(illegal_mask), .err_cnt(err_cnt), .err_sticky(err_sticky)
    );

    multi_mode_ff_bank #(.WIDTH(8), .RST_VAL(8'h00), .ERR_CNT_W(2)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .en(en), .mode(mode), .a(a), .b(b),
        .clr_err(clr_err), .q(q2), .qn(qn2), .illegal(illegal2),
        .illegal_mask(illegal_mask2), .err_cnt(err_cnt2), .err_sticky(err_sticky2)
    );

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        logic [7:0] exp_q;
        logic       exp_ill;
        logic [7:0] exp_mask;
        logic [7:0] exp_cnt;
        logic [1:0] exp_cnt2;
        logic       exp_sticky;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_reset();
        m_q = 8'h00; m_ill = 1'b0; m_mask = 8'h00;
        m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
    endfunction

    // Behaviour written from the per-bit flip-flop rules and plain integer counting.
    function automatic void model_step(input logic e, input logic [1:0] md,
                                       input logic [7:0] va, input logic [7:0] vb,
                                       input logic clr);
        logic [7:0] nq;
        logic [7:0] vm;
        nq = m_q;
        vm = 8'h00;
        if (e) begin
            for (int i = 0; i < 8; i++) begin
                case (md)
                    2'd0: begin
                        if (va[i] && vb[i])  vm[i] = 1'b1;
                        else if (va[i])      nq[i] = 1'b1;
                        else if (vb[i])      nq[i] = 1'b0;
                    end
                    2'd1: begin
                        if (va[i] && vb[i])  nq[i] = !m_q[i];
                        else if (va[i])      nq[i] = 1'b1;
                        else if (vb[i])      nq[i] = 1'b0;
                    end
                    2'd2: nq[i] = va[i];
                    default: if (va[i]) nq[i] = !m_q[i];
                endcase
            end
        end
        m_q    = nq;
        m_mask = vm;
        m_ill  = (vm != 8'h00);
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
        end else if (m_ill) begin
            m_sticky = 1'b1;
            m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
            m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
        end
    endfunction

    // Apply inputs, advance the model and the DUT by one edge, sample 1 ns later.
    task automatic step(input logic e, input logic [1:0] md, input logic [7:0] va,
                        input logic [7:0] vb, input logic clr);
        en = e; mode = md; a = va; b = vb; clr_err = clr;
        model_step(e, md, va, vb, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " q"},      {24'd0, q},  {24'd0, m_q});
        chk({tag, " qn"},     {24'd0, qn}, {24'd0, ~m_q});
        chk({tag, " flags"},  {14'd0, illegal, illegal_mask, err_cnt, err_sticky},
                              {14'd0, m_ill, m_mask, m_cnt8[7:0], m_sticky});
        chk({tag, " cnt2"},   {29'd0, err_cnt2, err_sticky2},
                              {29'd0, m_cnt2[1:0], m_sticky});
    endtask

    initial begin
        // Directed table: starts from q=0x00 with counters clear.
        //             en mode  a      b      clr  q      ill  mask   cnt    cnt2  st
        vecs.push_back('{1'b1, 2'd0, 8'h0F, 8'h00, 1'b0, 8'h0F, 1'b0, 8'h00, 8'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 8'h00, 8'h03, 1'b0, 8'h0C, 1'b0, 8'h00, 8'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 8'hF0, 8'hF0, 1'b0, 8'h0C, 1'b1, 8'hF0, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'h0C, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 8'hF3, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 8'h0C, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 2'd1, 8'h01, 8'h04, 1'b0, 8'h09, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 2'd3, 8'h0F, 8'h00, 1'b0, 8'hAA, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 2'd3, 8'hFF, 8'h00, 1'b0, 8'hAA, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0, 8'hAA, 1'b0, 8'h00, 8'd1, 2'd1, 1'b1});
        // Clear, then five violations to saturate the 2-bit counter.
        vecs.push_back('{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'hAA, 1'b0, 8'h00, 8'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'hAA, 1'b1, 8'h01, 8'd1, 2'd1, 1'b1});
        vecs.push_back('{1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'hAA, 1'b1, 8'h01, 8'd2, 2'd2, 1'b1});
        vecs.push_back('{1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'hAA, 1'b1, 8'h01, 8'd3, 2'd3, 1'b1});
        vecs.push_back('{1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'hAA, 1'b1, 8'h01, 8'd4, 2'd3, 1'b1});
        vecs.push_back('{1'b1, 2'd0, 8'h01, 8'h01, 1'b0, 8'hAA, 1'b1, 8'h01, 8'd5, 2'd3, 1'b1});
        // Clear beats a simultaneous violation; illegal still reports it.
        vecs.push_back('{1'b1, 2'd0, 8'h81, 8'h81, 1'b1, 8'hAA, 1'b1, 8'h81, 8'd0, 2'd0, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'hAA, 1'b0, 8'h00, 8'd0, 2'd0, 1'b0});

        // Reset at time 0, checked before any clock edge.
        n_rst = 1'b0; en = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00; clr_err = 1'b0;
        model_reset();
        #2;
        chk("reset q",   {24'd0, q},  32'h00);
        chk("reset qn",  {24'd0, qn}, 32'hFF);
        chk("reset err", {22'd0, illegal, illegal_mask, err_cnt, err_sticky}, 32'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // Load 0x5A, then pulse reset between edges.
        step(1'b1, 2'd2, 8'h5A, 8'h00, 1'b0);
        chk("load 5A", {24'd0, q}, 32'h5A);
        step(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
        chk("pre-reset illegal", {31'd0, illegal}, 32'h1);
        n_rst = 1'b0;
        #2;
        chk("async reset q",  {24'd0, q},  32'h00);
        chk("async reset qn", {24'd0, qn}, 32'hFF);
        chk("async reset err", {22'd0, illegal, illegal_mask, err_cnt, err_sticky}, 32'h0);
        n_rst = 1'b1;
        model_reset();

        foreach (vecs[k]) begin
            step(vecs[k].en, vecs[k].mode, vecs[k].a, vecs[k].b, vecs[k].clr);
            chk($sformatf("vec%0d q", k), {24'd0, q}, {24'd0, vecs[k].exp_q});
            chk($sformatf("vec%0d qn", k), {24'd0, qn}, {24'd0, ~vecs[k].exp_q});
            chk($sformatf("vec%0d flags", k),
                {14'd0, illegal, illegal_mask, err_cnt, err_sticky},
                {14'd0, vecs[k].exp_ill, vecs[k].exp_mask, vecs[k].exp_cnt, vecs[k].exp_sticky});
            chk($sformatf("vec%0d cnt2", k), {30'd0, err_cnt2}, {30'd0, vecs[k].exp_cnt2});
        end

        // Mode switch: SR violation, then JK toggle of bit0 on the next edge.
        step(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
        chk("sw viol ill", {31'd0, illegal}, 32'h1);
        chk("sw viol q",   {24'd0, q}, 32'hAA);
        step(1'b1, 2'd1, 8'h01, 8'h01, 1'b0);
        chk("sw jk ill", {31'd0, illegal}, 32'h0);
        chk("sw jk q",   {24'd0, q}, 32'hAB);
        chk("sw jk cnt", {24'd0, err_cnt}, 32'h1);
        step(1'b1, 2'd0, 8'h00, 8'h00, 1'b0);
        chk("sw after ill", {31'd0, illegal}, 32'h0);

        // Randomised run against the reference model.
        for (int n = 0; n < 200; n++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
            chk_model($sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_mode_ff_bank.md
Name: multi_mode_ff_bank

Overview:
- Parametrised, multi-bit successor to the single-bit SR flip-flop.
- Holds a WIDTH-bit register bank. A run-time mode selects SR, JK, D or T flip-flop behaviour for all bits.
- Detects illegal SR input combinations per bit and keeps a saturating violation counter with a sticky flag.
- Used as a general control/status register primitive and as a stimulus target for flip-flop lab benches.

Parameters:
- WIDTH, 8: number of flip-flop bits in the bank.
- RST_VAL, 0: value loaded into q on reset (WIDTH bits).
- ERR_CNT_W, 8: width of the violation counter.

Ports:
- clk  input  1  rising-edge clock.
- n_rst  input  1  asynchronous active-low reset.
- en  input  1  update enable; 0 = whole bank holds.
- mode  input  2  00 SR, 01 JK, 10 D, 11 T.
- a  input  WIDTH  per-bit S / J / D / T input, depending on mode.
- b  input  WIDTH  per-bit R / K input; ignored in D and T modes.
- clr_err  input  1  synchronous clear of err_cnt and err_sticky.
- q  output  WIDTH  registered state.
- qn  output  WIDTH  always ~q, derived from q (not a second flop).
- illegal  output  1  registered; 1 for one cycle after an SR violation.
- illegal_mask  output  WIDTH  registered per-bit violation bits for that cycle.
- err_cnt  output  ERR_CNT_W  saturating count of violation cycles.
- err_sticky  output  1  set on any violation, held until clr_err.

Behaviour:
- Reset (n_rst=0): effective immediately, with no clock edge needed.
  - q=RST_VAL, qn=~RST_VAL.
  - illegal=0, illegal_mask=0, err_cnt=0, err_sticky=0.
  - Reset asserted mid-operation overrides everything.
  - After release, the first update occurs on the next rising edge.
- Sampling: all inputs, including mode, are sampled at the rising edge. A mode change applies on the same edge; there is no pipeline.
- en=0: q holds for every bit, no violation is detected, illegal and illegal_mask go to 0 on that edge.
- en=1, per bit i:
  - SR mode: a=1,b=0 sets; a=0,b=1 resets; 0/0 holds; 1/1 is illegal. On illegal, q[i] holds and illegal_mask[i]=1.
  - JK mode: 1/0 sets, 0/1 resets, 0/0 holds, 1/1 toggles. Never illegal.
  - D mode: q[i]=a[i].
  - T mode: a[i]=1 toggles, a[i]=0 holds.
- Violation cycle: en=1, mode=SR and (a & b) != 0.
  - illegal=1 and illegal_mask=(a & b) on the following cycle.
  - Otherwise illegal=0 and illegal_mask=0.
  - illegal is a pulse per violating cycle, not latched.
- Counting:
  - err_cnt increments by exactly 1 per violation cycle, regardless of how many bits violate.
  - err_cnt saturates at 2^ERR_CNT_W-1 and never wraps.
  - err_sticky is set on any violation cycle.
- clr_err:
  - On the edge where clr_err=1: err_cnt=0, err_sticky=0.
  - clr_err beats a simultaneous violation, so that cycle's violation is not counted and sticky stays 0.
  - illegal and illegal_mask still report the simultaneous violation.
  - clr_err does not affect q.
- Latency: q, illegal and err_cnt reflect inputs one clock after sampling. qn follows q combinationally.

Test Plan (WIDTH=8, RST_VAL=0 unless stated):
1. Reset:
   - n_rst=0 at time 0: q=0x00, qn=0xFF, err_cnt=0.
   - Drive q to 0x5A, then pulse n_rst low between edges: q=0x00 before the next edge.
2. SR, mode=00, en=1:
   - a=0x0F, b=0x00: q=0x0F.
   - a=0x00, b=0x03: q=0x0C.
   - a=0xF0, b=0xF0: q stays 0x0C, illegal=1, illegal_mask=0xF0, err_cnt=1, err_sticky=1.
   - a=b=0: illegal returns to 0.
3. JK, mode=01, from q=0x0C:
   - a=b=0xFF for two cycles: q=0xF3, then 0x0C, with illegal=0 throughout.
   - a=0x01, b=0x04: q=0x09.
4. D / T / enable:
   - mode=10, a=0xA5: q=0xA5.
   - mode=11, a=0x0F: q=0xAA.
   - en=0 with a=0xFF in T mode: q holds 0xAA.
   - en=0, mode=SR, a=b=0xFF: illegal=0, err_cnt unchanged.
5. Saturation and clear (ERR_CNT_W=2):
   - Five consecutive SR violation cycles: err_cnt=1,2,3,3,3.
   - Then clr_err=1 together with a violation: err_cnt=0, err_sticky=0, illegal=1.
   - Next clean cycle: illegal=0.
6. Mode switch:
   - SR violation on one edge, then mode=01 with a=b=0x01 on the next edge: illegal pulses once only and bit0 toggles.
   - Per-edge checks: q equals a reference model for 200 random cycles covering all modes and en values.
